// File: rtl/servo_pkg.sv
// Shared constants, opcodes, FSM encodings and command payload for the servo ramp controller.
package servo_pkg;

    localparam int unsigned NCH        = 8;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned CHAN_W     = 3;
    localparam int unsigned OP_W       = 2;

    localparam int unsigned PERIOD_DEF = 1000000;
    localparam int unsigned PERIOD_MIN = 256;
    localparam int unsigned D_MIN      = 50000;
    localparam int unsigned D_MAX      = 100000;
    localparam int unsigned D_CENTER   = 75000;
    localparam int unsigned STEP       = 500;
    localparam int unsigned TICK_DIV   = 50000;

    localparam logic [OP_W-1:0] OP_SET_TGT = 2'd0;
    localparam logic [OP_W-1:0] OP_EN      = 2'd1;
    localparam logic [OP_W-1:0] OP_DIS     = 2'd2;
    localparam logic [OP_W-1:0] OP_PERIOD  = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [CHAN_W-1:0] chan;
        logic [CNT_W-1:0]  data;
    } cmd_t;

endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// Valid/ready command channel feeding the servo ramp controller.
interface servo_ramp_ctrl_if
    import servo_pkg::*;
#(
    parameter int unsigned DATA_W = CNT_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [CHAN_W-1:0] cmd_chan;
    logic [DATA_W-1:0] cmd_data;

    modport master (output cmd_valid, cmd_op, cmd_chan, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_chan, cmd_data, output cmd_ready);
endinterface

// File: rtl/servo_ramp_step.sv
// Next pulse width for one channel: move toward target by at most one step, never overshooting.
module servo_ramp_step
    import servo_pkg::*;
#(
    parameter int unsigned W       = CNT_W,
    parameter int unsigned STEP_SZ = STEP
) (
    input  logic [W-1:0] duty,
    input  logic [W-1:0] target,
    input  logic         en,
    output logic [W-1:0] duty_next_c
);
    localparam logic [W-1:0] STEP_V = W'(STEP_SZ);

    // Distance is compared first so the add/subtract can never wrap.
    always_comb begin
        duty_next_c = duty;
        if (en) begin
            if (duty < target) begin
                duty_next_c = ((target - duty) > STEP_V) ? duty + STEP_V : target;
            end else if (duty > target) begin
                duty_next_c = ((duty - target) > STEP_V) ? duty - STEP_V : target;
            end
        end
    end
endmodule

// File: rtl/servo_ramp_ctrl.sv
// Per-channel servo setpoint stage: applies commands and slews live pulse widths once per ramp tick.
module servo_ramp_ctrl #(
    parameter int unsigned NCH        = servo_pkg::NCH,
    parameter int unsigned CNT_W      = servo_pkg::CNT_W,
    parameter int unsigned PERIOD_DEF = servo_pkg::PERIOD_DEF,
    parameter int unsigned PERIOD_MIN = servo_pkg::PERIOD_MIN,
    parameter int unsigned D_MIN      = servo_pkg::D_MIN,
    parameter int unsigned D_MAX      = servo_pkg::D_MAX,
    parameter int unsigned D_CENTER   = servo_pkg::D_CENTER,
    parameter int unsigned STEP       = servo_pkg::STEP,
    parameter int unsigned TICK_DIV   = servo_pkg::TICK_DIV
) (
    input  logic                 clk,
    input  logic                 rst_n,
    servo_ramp_ctrl_if.slave     cmd,
    output logic [CNT_W-1:0]     period_o,
    output logic [NCH*CNT_W-1:0] duty_o,
    output logic [NCH-1:0]       enable_o,
    output logic [NCH-1:0]       at_target_o,
    output logic                 busy_o,
    output logic                 tick_overrun_o
);
    import servo_pkg::*;

    localparam int unsigned IDX_W  = $clog2(NCH);
    localparam int unsigned TICK_W = $clog2(TICK_DIV);

    logic [1:0]        state_q, state_n;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_n;
    logic              pending_q, pending_n;
    logic              overrun_q, overrun_n;
    logic [IDX_W-1:0]  idx_q, idx_n;
    cmd_t              cmd_q, cmd_n;
    logic              ready_q, ready_n;
    logic              busy_q, busy_n;
    logic [CNT_W-1:0]  period_q, period_n;
    logic [CNT_W-1:0]  duty_q [NCH];
    logic [CNT_W-1:0]  duty_n [NCH];
    logic [CNT_W-1:0]  tgt_q  [NCH];
    logic [CNT_W-1:0]  tgt_n  [NCH];
    logic [NCH-1:0]    en_q, en_n;
    logic [NCH-1:0]    at_tgt_q, at_tgt_n;
    logic [CNT_W-1:0]  step_duty_c;
    logic              wrap_c;

    servo_ramp_step #(.W(CNT_W), .STEP_SZ(STEP)) u_step (
        .duty        (duty_q[idx_q]),
        .target      (tgt_q[idx_q]),
        .en          (en_q[idx_q]),
        .duty_next_c (step_duty_c)
    );

    assign wrap_c = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    // Next-state and datapath update.
    always_comb begin
        state_n    = state_q;
        tick_cnt_n = wrap_c ? '0 : tick_cnt_q + TICK_W'(1);
        pending_n  = pending_q | wrap_c;
        overrun_n  = overrun_q | (wrap_c & pending_q);
        idx_n      = idx_q;
        cmd_n      = cmd_q;
        period_n   = period_q;
        duty_n     = duty_q;
        tgt_n      = tgt_q;
        en_n       = en_q;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_n   = ST_SWEEP;
                    pending_n = wrap_c;
                    idx_n     = '0;
                end else if (cmd.cmd_valid && ready_q) begin
                    cmd_n.op   = cmd.cmd_op;
                    cmd_n.chan = cmd.cmd_chan;
                    cmd_n.data = cmd.cmd_data;
                    state_n    = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_n = ST_IDLE;
                case (cmd_q.op)
                    OP_SET_TGT: begin
                        if (cmd_q.data < CNT_W'(D_MIN))      tgt_n[cmd_q.chan] = CNT_W'(D_MIN);
                        else if (cmd_q.data > CNT_W'(D_MAX)) tgt_n[cmd_q.chan] = CNT_W'(D_MAX);
                        else                                 tgt_n[cmd_q.chan] = cmd_q.data;
                    end
                    OP_EN:   en_n[cmd_q.chan] = 1'b1;
                    OP_DIS:  en_n[cmd_q.chan] = 1'b0;
                    default: period_n = (cmd_q.data < CNT_W'(PERIOD_MIN)) ? CNT_W'(PERIOD_MIN) : cmd_q.data;
                endcase
            end
            ST_SWEEP: begin
                duty_n[idx_q] = step_duty_c;
                if (idx_q == IDX_W'(NCH - 1)) state_n = ST_IDLE;
                else                          idx_n   = idx_q + IDX_W'(1);
            end
            default: state_n = ST_IDLE;
        endcase

        ready_n = (state_n == ST_IDLE) && !pending_n;
        busy_n  = (state_n != ST_IDLE);
        for (int i = 0; i < NCH; i++) at_tgt_n[i] = (duty_n[i] == tgt_n[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            idx_q      <= '0;
            cmd_q      <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            period_q   <= CNT_W'(PERIOD_DEF);
            en_q       <= '0;
            at_tgt_q   <= '1;
            for (int i = 0; i < NCH; i++) begin
                duty_q[i] <= CNT_W'(D_CENTER);
                tgt_q[i]  <= CNT_W'(D_CENTER);
            end
        end else begin
            state_q    <= state_n;
            tick_cnt_q <= tick_cnt_n;
            pending_q  <= pending_n;
            overrun_q  <= overrun_n;
            idx_q      <= idx_n;
            cmd_q      <= cmd_n;
            ready_q    <= ready_n;
            busy_q     <= busy_n;
            period_q   <= period_n;
            en_q       <= en_n;
            at_tgt_q   <= at_tgt_n;
            for (int i = 0; i < NCH; i++) begin
                duty_q[i] <= duty_n[i];
                tgt_q[i]  <= tgt_n[i];
            end
        end
    end

    assign cmd.cmd_ready   = ready_q;
    assign period_o        = period_q;
    assign enable_o        = en_q;
    assign at_target_o     = at_tgt_q;
    assign busy_o          = busy_q;
    assign tick_overrun_o  = overrun_q;

    for (genvar g = 0; g < NCH; g++) begin : g_duty
        assign duty_o[g*CNT_W +: CNT_W] = duty_q[g];
    end
endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed plus randomized check of servo_ramp_ctrl against a per-tick behavioural model.
module tb_servo_ramp_ctrl;
    localparam int NCH = 8;
    localparam int W   = 32;
    localparam int STEP = 10, DMIN = 100, DMAX = 200, DCEN = 150, PDEF = 2000, PMIN = 256;

    logic clk = 1'b0;
    logic rst_n;
    logic [W-1:0]     period_o;
    logic [NCH*W-1:0] duty_o;
    logic [NCH-1:0]   enable_o, at_target_o;
    logic             busy_o, tick_overrun_o;

    servo_ramp_ctrl_if #(.DATA_W(W)) cmd_if ();

    servo_ramp_ctrl #(
        .NCH(NCH), .CNT_W(W), .PERIOD_DEF(PDEF), .PERIOD_MIN(PMIN), .D_MIN(DMIN),
        .D_MAX(DMAX), .D_CENTER(DCEN), .STEP(STEP), .TICK_DIV(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_if),
        .period_o(period_o), .duty_o(duty_o), .enable_o(enable_o),
        .at_target_o(at_target_o), .busy_o(busy_o), .tick_overrun_o(tick_overrun_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int m_duty [NCH];
    int m_tgt  [NCH];
    bit m_en   [NCH];
    int m_period;
    int run_len = 0, ready_bad = 0, sweeps_done = 0;
    bit in_sweep = 0;
    int up_exp [4] = '{160, 170, 180, 183};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] duty_of(input int i);
        return duty_o[i*W +: W];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin m_duty[i] = DCEN; m_tgt[i] = DCEN; m_en[i] = 0; end
        m_period = PDEF;
    endtask

    // One ramp tick: every enabled channel moves toward its target by up to STEP.
    task automatic model_tick();
        for (int i = 0; i < NCH; i++) begin
            if (m_en[i]) begin
                if (m_tgt[i] > m_duty[i])      m_duty[i] += (m_tgt[i] - m_duty[i] < STEP) ? m_tgt[i] - m_duty[i] : STEP;
                else if (m_tgt[i] < m_duty[i]) m_duty[i] -= (m_duty[i] - m_tgt[i] < STEP) ? m_duty[i] - m_tgt[i] : STEP;
            end
        end
    endtask

    task automatic model_cmd(input int op, input int ch, input int data);
        case (op)
            0: m_tgt[ch] = (data < DMIN) ? DMIN : (data > DMAX) ? DMAX : data;
            1: m_en[ch] = 1;
            2: m_en[ch] = 0;
            default: m_period = (data < PMIN) ? PMIN : data;
        endcase
    endtask

    task automatic check_all();
        logic [NCH-1:0] ev, av;
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("duty%0d", i), duty_of(i), m_duty[i]);
            ev[i] = m_en[i];
            av[i] = (m_duty[i] == m_tgt[i]);
        end
        chk("enable", enable_o, ev);
        chk("at_target", at_target_o, av);
        chk("period", period_o, m_period);
        chk("overrun", tick_overrun_o, 0);
    endtask

    // Advance to the next falling edge; a busy run of two or more samples is a sweep.
    task automatic cycle();
        @(negedge clk);
        if (busy_o) begin
            run_len++;
            if (cmd_if.cmd_ready) ready_bad++;
            if (run_len == 2) begin in_sweep = 1; model_tick(); end
        end else begin
            if (in_sweep) begin
                chk("sweep_len", run_len, NCH);
                chk("ready_high_while_busy", ready_bad, 0);
                in_sweep = 0;
                sweeps_done++;
                check_all();
            end
            run_len = 0;
            ready_bad = 0;
        end
    endtask

    task automatic send_cmd(input int op, input int ch, input int data);
        int lim = 100;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'(op);
        cmd_if.cmd_chan  = 3'(ch);
        cmd_if.cmd_data  = W'(data);
        while (cmd_if.cmd_ready !== 1'b1 && lim > 0) begin cycle(); lim--; end
        chk("cmd_ready_seen", cmd_if.cmd_ready, 1);
        cycle();
        cmd_if.cmd_valid = 1'b0;
        model_cmd(op, ch, data);
    endtask

    task automatic settle();
        cycle();
        if (!in_sweep && !busy_o) check_all();
    endtask

    task automatic wait_sweeps(input int n);
        int goal = sweeps_done + n;
        int lim = 40 * n + 40;
        while (sweeps_done < goal && lim > 0) begin cycle(); lim--; end
        chk("sweep_arrived", sweeps_done >= goal, 1);
    endtask

    task automatic rand_cmd();
        int op = $urandom_range(0, 3);
        send_cmd(op, $urandom_range(0, NCH - 1), (op == 3) ? $urandom_range(0, 3000) : $urandom_range(0, 300));
    endtask

    initial begin
        int s0, lim;
        rst_n = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op = '0;
        cmd_if.cmd_chan = '0;
        cmd_if.cmd_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        chk("busy_in_reset", busy_o, 0);
        rst_n = 1'b1;
        cycle();
        chk("ready_after_reset", cmd_if.cmd_ready, 1);

        // Ramp up ch3 to 183
        send_cmd(1, 3, 0);
        send_cmd(0, 3, 183);
        for (int k = 0; k < 4; k++) begin
            wait_sweeps(1);
            chk($sformatf("ramp_up_%0d", k), duty_of(3), up_exp[k]);
        end
        chk("ramp_up_at_target", at_target_o[3], 1);
        chk("ramp_up_ch4_still", duty_of(4), DCEN);

        // Clamping
        send_cmd(0, 0, 20);
        settle();
        chk("clamp_ch0_not_at_tgt", at_target_o[0], 0);
        send_cmd(3, 0, 5);
        settle();
        chk("period_clamp", period_o, PMIN);
        send_cmd(1, 0, 0);
        send_cmd(0, 1, 999);
        send_cmd(1, 1, 0);
        wait_sweeps(6);
        chk("clamp_low_ch0", duty_of(0), DMIN);
        chk("clamp_high_ch1", duty_of(1), DMAX);

        // Disable mid-ramp on ch5
        send_cmd(0, 5, 100);
        send_cmd(1, 5, 0);
        wait_sweeps(2);
        chk("dis_pre", duty_of(5), 130);
        send_cmd(2, 5, 0);
        wait_sweeps(3);
        chk("dis_hold", duty_of(5), 130);
        send_cmd(1, 5, 0);
        wait_sweeps(1); chk("resume_120", duty_of(5), 120);
        wait_sweeps(1); chk("resume_110", duty_of(5), 110);
        wait_sweeps(1); chk("resume_100", duty_of(5), 100);

        // Async reset in the middle of a sweep (index 4) with ch2 at 170
        send_cmd(0, 2, 200);
        send_cmd(1, 2, 0);
        wait_sweeps(2);
        chk("ch2_pre_reset", duty_of(2), 170);
        lim = 60;
        while (!in_sweep && lim > 0) begin cycle(); lim--; end
        chk("sweep_started", in_sweep, 1);
        repeat (3) cycle();
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        in_sweep = 0; run_len = 0; ready_bad = 0;
        check_all();
        chk("busy_async_reset", busy_o, 0);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("ready_after_async_reset", cmd_if.cmd_ready, 1);

        // Back-to-back burst of 16 commands spanning a tick
        s0 = sweeps_done;
        for (int k = 0; k < 16; k++) rand_cmd();
        settle();
        chk("burst_crossed_tick", sweeps_done > s0, 1);

        // Randomized commands with random gaps
        for (int k = 0; k < 40; k++) begin
            rand_cmd();
            repeat ($urandom_range(0, 12)) cycle();
        end
        wait_sweeps(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/servo_ramp_ctrl.md
Name: servo_ramp_ctrl

Overview:
- Command-driven setpoint stage that sits directly upstream of the 8-channel servo PWM generator.
- Accepts per-channel commands over a valid/ready interface: target pulse width, enable, disable, period.
- Slews each enabled channel's live pulse width toward its target by a fixed step once per ramp tick.
- Drives the period, duty and enable inputs of the PWM generator.

Parameters:
- NCH, 8: number of servo channels (channel index width is 3).
- CNT_W, 32: width of period/duty values in clk cycles.
- PERIOD_DEF, 1000000: reset period (20 ms at 50 MHz).
- PERIOD_MIN, 256: smallest accepted period; smaller writes are clamped up to it.
- D_MIN, 50000: lowest legal pulse width (1.0 ms).
- D_MAX, 100000: highest legal pulse width (2.0 ms).
- D_CENTER, 75000: reset duty and reset target for all channels.
- STEP, 500: maximum duty change per ramp tick.
- TICK_DIV, 50000: clk cycles per ramp tick; must be >= 2*NCH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_op  in  2  0 = set target, 1 = enable, 2 = disable, 3 = set period (global).
- cmd_chan  in  3  channel index; ignored for op 3.
- cmd_data  in  CNT_W  target or period value.
- period_o  out  CNT_W  common PWM period.
- duty_o  out  NCH*CNT_W  live pulse widths; channel i occupies bits [i*CNT_W +: CNT_W].
- enable_o  out  NCH  per-channel PWM enable.
- at_target_o  out  NCH  per-channel flag: duty equals target.
- busy_o  out  1  high during the apply or sweep phase.
- tick_overrun_o  out  1  sticky flag; cleared only by reset.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - period_o = PERIOD_DEF.
  - Every duty and every target = D_CENTER.
  - enable_o = 0, at_target_o = all 1, busy_o = 0, tick_overrun_o = 0.
  - Tick counter = 0, tick_pending = 0, FSM = IDLE.
  - cmd_ready = 1 from the first clock edge after rst_n rises.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - At the wrap it sets tick_pending.
  - If tick_pending is already set at the wrap, tick_overrun_o is set.
- FSM states: IDLE, APPLY, SWEEP.
- IDLE:
  - cmd_ready = 1 only when tick_pending = 0.
  - tick_pending = 1 has priority: go to SWEEP, clear tick_pending, cmd_ready = 0.
  - Otherwise cmd_valid & cmd_ready latches the command and goes to APPLY.
- APPLY (1 cycle), then return to IDLE; busy_o = 1:
  - op 0: target[chan] = cmd_data clamped to [D_MIN, D_MAX].
  - op 1: enable[chan] = 1.
  - op 2: enable[chan] = 0.
  - op 3: period = max(cmd_data, PERIOD_MIN).
  - Each update is visible on its output the cycle after APPLY.
- SWEEP: NCH cycles, index 0..NCH-1, one channel per cycle; busy_o = 1. Return to IDLE after index NCH-1.
- Ramp rule for channel i in its sweep cycle, if enabled:
  - duty < target: duty = min(duty+STEP, target).
  - duty > target: duty = max(duty-STEP, target).
  - Disabled channels hold their duty.
- Ramp arithmetic: compare before adding/subtracting, so no wrap-around occurs at the CNT_W limits.
- at_target_o[i] = (duty[i] == target[i]); registered.
- Handshake boundaries:
  - A command arriving during APPLY or SWEEP is held by the source; cmd_ready = 0 and nothing is dropped.
  - cmd_valid is sampled only when cmd_ready = 1.
- Disable mid-ramp: duty freezes at its current value. A later enable resumes the ramp from that value.
- A target write during an active ramp redirects the ramp from the current duty on the next tick. No jump occurs.
- Reset asserted mid-sweep: immediate return to all reset values.

Decomposition:
- Shared package servo_pkg:
  - localparams for opcodes OP_SET_TGT = 0, OP_EN = 1, OP_DIS = 2, OP_PERIOD = 3.
  - Default timing constants: PERIOD_DEF, D_MIN, D_MAX, D_CENTER, STEP, TICK_DIV.
  - FSM state encodings.
- One natural sub-module: servo_ramp_step.
  - Combinational next-duty = f(duty, target, STEP, enable).
  - Instantiated once and muxed by the sweep index.
  - Lets verification check it in isolation.

Test Plan:
Bench parameters: TICK_DIV = 20, STEP = 10, D_MIN = 100, D_MAX = 200, D_CENTER = 150, PERIOD_DEF = 2000, PERIOD_MIN = 256.
- Reset: hold rst_n low, release -> period_o = 2000, all duty = 150, enable_o = 0, at_target_o = 0xFF, cmd_ready = 1 on the next edge.
- Ramp up: enable ch3, set target ch3 = 183 -> ch3 duty goes 160, 170, 180, 183 on four successive ticks; at_target_o[3] = 1 after the fourth. Other channels stay at 150.
- Clamping: target ch0 = 20 -> target stored 100. Period = 5 -> period_o = 256. Target ch1 = 999 -> ramp stops at 200.
- Disable mid-ramp: ch5 ramping 150 -> 100, disable at duty 130 -> holds 130 across 3 ticks. Re-enable -> 120, 110, 100.
- Handshake: hold cmd_valid with 16 back-to-back commands spanning a tick -> cmd_ready drops for exactly NCH cycles during the sweep; all 16 commands applied, none lost.
- Async reset asserted at sweep index 4 with ch2 at 170 -> outputs return to reset values within the reset-assert cycle, without waiting for a clock edge; busy_o = 0.
